// File: rtl/framebuffer_write_scheduler.sv
// Port-B write scheduler for the RGB444 frame buffer: a per-frame clear sweep
// plus round-robin arbitration of the renderer and HUD pixel streams.
//
// state | meaning
// SERVE | arbitrate renderer/HUD requests, one accepted pixel per cycle
// CLEAR | sweep every address with CLEAR_COLOR, requesters stalled
module framebuffer_write_scheduler #(
    parameter int          WIDTH       = 512,
    parameter int          HEIGHT      = 384,
    parameter int          ADDR_W      = $clog2(WIDTH * HEIGHT),
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_start_in,
    input  logic              render_valid_in,
    output logic              render_ready_out,
    input  logic [10:0]       render_x_in,
    input  logic [9:0]        render_y_in,
    input  logic [11:0]       render_pixel_in,
    input  logic              hud_valid_in,
    output logic              hud_ready_out,
    input  logic [10:0]       hud_x_in,
    input  logic [9:0]        hud_y_in,
    input  logic [11:0]       hud_pixel_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [11:0]       mem_data_out,
    output logic              mem_we_out,
    output logic              clearing_out,
    output logic              clear_done_out,
    output logic              overrun_out,
    output logic [15:0]       oob_count_out
);

    typedef enum logic {SERVE, CLEAR} state_t;

    localparam int                X_BITS    = $clog2(WIDTH);
    localparam logic [10:0]       X_LIM     = 11'(WIDTH);
    localparam logic [9:0]        Y_LIM     = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state;
    logic              last_grant_hud;
    logic [ADDR_W-1:0] clr_cnt;

    logic        serving;
    logic        grant_render;
    logic        grant_hud;
    logic [10:0] sel_x;
    logic [9:0]  sel_y;
    logic [11:0] sel_pixel;
    logic        in_range;
    logic [20:0] lin_addr;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        serving          = (state == SERVE) && !frame_start_in;
        grant_render     = render_valid_in && (!hud_valid_in || last_grant_hud);
        grant_hud        = hud_valid_in && (!render_valid_in || !last_grant_hud);
        render_ready_out = serving && grant_render;
        hud_ready_out    = serving && grant_hud;
        sel_x            = grant_hud ? hud_x_in     : render_x_in;
        sel_y            = grant_hud ? hud_y_in     : render_y_in;
        sel_pixel        = grant_hud ? hud_pixel_in : render_pixel_in;
        in_range         = (sel_x < X_LIM) && (sel_y < Y_LIM);
        lin_addr         = (21'(sel_y) << X_BITS) + 21'(sel_x);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= SERVE;
            last_grant_hud <= 1'b1;
            clr_cnt        <= '0;
            mem_addr_out   <= '0;
            mem_data_out   <= '0;
            mem_we_out     <= 1'b0;
            clearing_out   <= 1'b0;
            clear_done_out <= 1'b0;
            overrun_out    <= 1'b0;
            oob_count_out  <= '0;
        end else begin
            mem_we_out     <= 1'b0;
            clearing_out   <= 1'b0;
            clear_done_out <= 1'b0;
            case (state)
                SERVE: begin
                    if (frame_start_in) begin
                        state        <= CLEAR;
                        mem_addr_out <= '0;
                        mem_data_out <= CLEAR_COLOR;
                        mem_we_out   <= 1'b1;
                        clearing_out <= 1'b1;
                        clr_cnt      <= ADDR_W'(1);
                    end else if (grant_render || grant_hud) begin
                        last_grant_hud <= grant_hud;
                        if (in_range) begin
                            mem_addr_out <= lin_addr[ADDR_W-1:0];
                            mem_data_out <= sel_pixel;
                            mem_we_out   <= 1'b1;
                        end else if (oob_count_out != 16'hFFFF) begin
                            oob_count_out <= oob_count_out + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    if (frame_start_in) overrun_out <= 1'b1;
                    // Stay in CLEAR through the last-write cycle so ready
                    // remains low while clear_done_out is visible.
                    if (clear_done_out) begin
                        state <= SERVE;
                    end else begin
                        mem_addr_out   <= clr_cnt;
                        mem_data_out   <= CLEAR_COLOR;
                        mem_we_out     <= 1'b1;
                        clearing_out   <= 1'b1;
                        clear_done_out <= (clr_cnt == LAST_ADDR);
                        clr_cnt        <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Directed bench for framebuffer_write_scheduler, built with a short frame
// (512x4) so the clear sweep is 2048 writes.
module tb_framebuffer_write_scheduler;

    localparam int WIDTH  = 512;
    localparam int HEIGHT = 4;
    localparam int N_PIX  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(N_PIX);

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              frame_start_in;
    logic              render_valid_in;
    logic              render_ready_out;
    logic [10:0]       render_x_in;
    logic [9:0]        render_y_in;
    logic [11:0]       render_pixel_in;
    logic              hud_valid_in;
    logic              hud_ready_out;
    logic [10:0]       hud_x_in;
    logic [9:0]        hud_y_in;
    logic [11:0]       hud_pixel_in;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [11:0]       mem_data_out;
    logic              mem_we_out;
    logic              clearing_out;
    logic              clear_done_out;
    logic              overrun_out;
    logic [15:0]       oob_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    framebuffer_write_scheduler #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .CLEAR_COLOR(12'h000)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
        .render_valid_in(render_valid_in), .render_ready_out(render_ready_out),
        .render_x_in(render_x_in), .render_y_in(render_y_in),
        .render_pixel_in(render_pixel_in),
        .hud_valid_in(hud_valid_in), .hud_ready_out(hud_ready_out),
        .hud_x_in(hud_x_in), .hud_y_in(hud_y_in), .hud_pixel_in(hud_pixel_in),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_we_out(mem_we_out), .clearing_out(clearing_out),
        .clear_done_out(clear_done_out), .overrun_out(overrun_out),
        .oob_count_out(oob_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        repeat (2) step();
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in        = 1'b0;
        frame_start_in  = 1'b0;
        render_valid_in = 1'b0;
        render_x_in     = '0;
        render_y_in     = '0;
        render_pixel_in = '0;
        hud_valid_in    = 1'b0;
        hud_x_in        = '0;
        hud_y_in        = '0;
        hud_pixel_in    = '0;
        repeat (3) step();

        chk("rst_we",       32'(mem_we_out), 32'd0);
        chk("rst_addr",     32'(mem_addr_out), 32'd0);
        chk("rst_data",     32'(mem_data_out), 32'd0);
        chk("rst_clearing", 32'(clearing_out), 32'd0);
        chk("rst_done",     32'(clear_done_out), 32'd0);
        chk("rst_overrun",  32'(overrun_out), 32'd0);
        chk("rst_oob",      32'(oob_count_out), 32'd0);
        chk("rst_rready",   32'(render_ready_out), 32'd0);
        chk("rst_hready",   32'(hud_ready_out), 32'd0);
        rst_n_in = 1'b1;
        step();

        // single renderer pixel (3,2) -> 2*512+3 = 1027
        render_valid_in = 1'b1;
        render_x_in     = 11'd3;
        render_y_in     = 10'd2;
        render_pixel_in = 12'hF80;
        #1;
        chk("single_rready", 32'(render_ready_out), 32'd1);
        chk("single_hready", 32'(hud_ready_out), 32'd0);
        step();
        render_valid_in = 1'b0;
        chk("single_we",   32'(mem_we_out), 32'd1);
        chk("single_addr", 32'(mem_addr_out), 32'd1027);
        chk("single_data", 32'(mem_data_out), 32'hF80);
        step();
        chk("idle_we",   32'(mem_we_out), 32'd0);
        chk("idle_addr", 32'(mem_addr_out), 32'd1027);
        chk("idle_data", 32'(mem_data_out), 32'hF80);

        // round robin from reset: render(1,0)->1, hud(2,1)->514
        do_reset();
        render_valid_in = 1'b1;
        render_x_in     = 11'd1;
        render_y_in     = 10'd0;
        render_pixel_in = 12'h111;
        hud_valid_in    = 1'b1;
        hud_x_in        = 11'd2;
        hud_y_in        = 10'd1;
        hud_pixel_in    = 12'h222;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_rready", 32'(render_ready_out), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_hready", 32'(hud_ready_out),    (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            if (i == 3) begin
                render_valid_in = 1'b0;
                hud_valid_in    = 1'b0;
            end
            chk("rr_we",   32'(mem_we_out), 32'd1);
            chk("rr_addr", 32'(mem_addr_out), (i % 2 == 0) ? 32'd1 : 32'd514);
            chk("rr_data", 32'(mem_data_out), (i % 2 == 0) ? 32'h111 : 32'h222);
        end

        // out-of-range pixels are consumed without a write
        render_valid_in = 1'b1;
        render_x_in     = 11'd512;
        render_y_in     = 10'd0;
        #1;
        chk("oob_rready", 32'(render_ready_out), 32'd1);
        step();
        chk("oob_we_x", 32'(mem_we_out), 32'd0);
        render_x_in = 11'd0;
        render_y_in = 10'd4;
        step();
        render_valid_in = 1'b0;
        chk("oob_we_y",   32'(mem_we_out), 32'd0);
        chk("oob_addr",   32'(mem_addr_out), 32'd514);
        chk("oob_count2", 32'(oob_count_out), 32'd2);
        render_valid_in = 1'b1;
        render_x_in     = 11'd700;
        repeat (65532) step();
        chk("oob_fffe", 32'(oob_count_out), 32'hFFFE);
        step();
        chk("oob_ffff", 32'(oob_count_out), 32'hFFFF);
        step();
        render_valid_in = 1'b0;
        chk("oob_sat", 32'(oob_count_out), 32'hFFFF);

        // clear sweep with a pending renderer pixel (5,1) -> 517
        render_valid_in = 1'b1;
        render_x_in     = 11'd5;
        render_y_in     = 10'd1;
        render_pixel_in = 12'hABC;
        frame_start_in  = 1'b1;
        #1;
        chk("fs_rready", 32'(render_ready_out), 32'd0);
        step();
        frame_start_in = 1'b0;
        for (int i = 0; i < N_PIX; i++) begin
            chk("clr_rready",   32'(render_ready_out), 32'd0);
            chk("clr_we",       32'(mem_we_out), 32'd1);
            chk("clr_addr",     32'(mem_addr_out), 32'(i));
            chk("clr_data",     32'(mem_data_out), 32'h000);
            chk("clr_clearing", 32'(clearing_out), 32'd1);
            chk("clr_done",     32'(clear_done_out), (i == N_PIX - 1) ? 32'd1 : 32'd0);
            frame_start_in = (i == 100);
            step();
        end
        frame_start_in = 1'b0;
        chk("post_rready",   32'(render_ready_out), 32'd1);
        chk("post_we",       32'(mem_we_out), 32'd0);
        chk("post_clearing", 32'(clearing_out), 32'd0);
        chk("post_done",     32'(clear_done_out), 32'd0);
        step();
        render_valid_in = 1'b0;
        chk("pend_we",   32'(mem_we_out), 32'd1);
        chk("pend_addr", 32'(mem_addr_out), 32'd517);
        chk("pend_data", 32'(mem_data_out), 32'hABC);
        chk("overrun",   32'(overrun_out), 32'd1);
        step();
        chk("overrun_sticky", 32'(overrun_out), 32'd1);

        // asynchronous reset in the middle of a sweep
        frame_start_in = 1'b1;
        step();
        frame_start_in = 1'b0;
        repeat (10) step();
        chk("mid_clearing", 32'(clearing_out), 32'd1);
        chk("mid_addr",     32'(mem_addr_out), 32'd10);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_we",       32'(mem_we_out), 32'd0);
        chk("arst_clearing", 32'(clearing_out), 32'd0);
        chk("arst_addr",     32'(mem_addr_out), 32'd0);
        chk("arst_overrun",  32'(overrun_out), 32'd0);
        chk("arst_oob",      32'(oob_count_out), 32'd0);
        step();
        rst_n_in = 1'b1;
        step();
        chk("rel_we",       32'(mem_we_out), 32'd0);
        chk("rel_clearing", 32'(clearing_out), 32'd0);
        render_valid_in = 1'b1;
        render_x_in     = 11'd0;
        render_y_in     = 10'd0;
        render_pixel_in = 12'h005;
        #1;
        chk("rel_rready", 32'(render_ready_out), 32'd1);
        step();
        render_valid_in = 1'b0;
        chk("rel_wr_we",   32'(mem_we_out), 32'd1);
        chk("rel_wr_addr", 32'(mem_addr_out), 32'd0);
        chk("rel_wr_data", 32'(mem_data_out), 32'h005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
